// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default constants for the PLL-lock driven staged reset sequencer.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_STAGE_GAP     = 16;
    localparam int DEF_NUM_RESETS    = 3;

    localparam logic [7:0] LOSS_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == LOSS_MAX) begin
            result = LOSS_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_chain <= {STAGES{1'b0}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Holds staged domain resets until the PLL has been locked long enough, then
// releases them one stage at a time and re-asserts all of them on any lock loss.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP     = DEF_STAGE_GAP,
    parameter int NUM_RESETS    = DEF_NUM_RESETS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  locked,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            lock_loss_count,
    output logic [1:0]            state
);

    localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
    localparam int GAP_W    = $clog2(STAGE_GAP + 1);

    localparam logic [STABLE_W-1:0]   STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST    = GAP_W'(STAGE_GAP - 1);
    localparam logic [NUM_RESETS-1:0] ALL_ONES    = {NUM_RESETS{1'b1}};
    localparam logic [NUM_RESETS-1:0] ALL_ZEROS   = {NUM_RESETS{1'b0}};

    logic                  w_lock_s;
    seq_state_e            r_state;
    logic [STABLE_W-1:0]   r_stable_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [NUM_RESETS-1:0] r_rst_out;
    logic                  r_ready;
    logic [7:0]            r_loss_cnt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clock (clock),
        .i_reset (reset),
        .i_d     (locked),
        .o_q     (w_lock_s)
    );

    // Sequencer: lock qualification, staged release and lock-loss recovery.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= WAIT_LOCK;
            r_stable_cnt <= {STABLE_W{1'b0}};
            r_gap_cnt    <= {GAP_W{1'b0}};
            r_rst_out    <= ALL_ONES;
            r_ready      <= 1'b0;
            r_loss_cnt   <= 8'd0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    r_rst_out    <= ALL_ONES;
                    r_ready      <= 1'b0;
                    r_stable_cnt <= {STABLE_W{1'b0}};
                    r_gap_cnt    <= {GAP_W{1'b0}};
                    if (w_lock_s) begin
                        r_state <= STABILIZE;
                    end
                end
                STABILIZE: begin
                    // A dropout before qualification is not counted as a loss.
                    if (!w_lock_s) begin
                        r_state      <= WAIT_LOCK;
                        r_stable_cnt <= {STABLE_W{1'b0}};
                    end else if (r_stable_cnt == STABLE_LAST) begin
                        r_state      <= RELEASE;
                        r_stable_cnt <= {STABLE_W{1'b0}};
                        r_gap_cnt    <= {GAP_W{1'b0}};
                        r_rst_out    <= r_rst_out << 1;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + {{(STABLE_W-1){1'b0}}, 1'b1};
                    end
                end
                RELEASE: begin
                    // Loss is checked first so it beats a coincident stage release.
                    if (!w_lock_s) begin
                        r_state    <= WAIT_LOCK;
                        r_rst_out  <= ALL_ONES;
                        r_ready    <= 1'b0;
                        r_gap_cnt  <= {GAP_W{1'b0}};
                        r_loss_cnt <= sat_inc8(r_loss_cnt);
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= {GAP_W{1'b0}};
                        if (r_rst_out == ALL_ZEROS) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_rst_out <= r_rst_out << 1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + {{(GAP_W-1){1'b0}}, 1'b1};
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        r_state    <= WAIT_LOCK;
                        r_rst_out  <= ALL_ONES;
                        r_ready    <= 1'b0;
                        r_loss_cnt <= sat_inc8(r_loss_cnt);
                    end
                end
                default: begin
                    r_state   <= WAIT_LOCK;
                    r_rst_out <= ALL_ONES;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out         = r_rst_out;
    assign ready           = r_ready;
    assign lock_loss_count = r_loss_cnt;
    assign state           = r_state;

endmodule
